layer_2_5_sequencer: RTL and testbench

LAYER_2_5_SEQUENCER -- requirements
Module: layer_2_5_sequencer

---
 rtl/layer_2_5_sequencer.sv | 164 ++++++++++++++++
 tb/tb_layer_2_5_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_2_5_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_2_5_sequencer
// Purpose  : Control sequencer for a 5-lane MAC datapath. Clears the
//            accumulators, streams VEC_LEN operand reads, waits for the
//            datapath to acknowledge every step, then holds the result until
//            the consumer acknowledges it.
// Options  : define SEQ_TIMEOUT_EN to build in the drain watchdog and the
//            sticky 'error' output.
// Revision : 1.0 - initial release
// ============================================================================
module layer_2_5_sequencer #(
  parameter int VEC_LEN = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              result_ack,
  input  logic              dp_accumulate_signal,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              dp_clear,
  output logic              dp_load,
`ifdef SEQ_TIMEOUT_EN
  output logic              error,
`endif
  output logic              dp_accumulate
);

  // Counter width must hold VEC_LEN itself, which may equal 2^ADDR_W.
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  VEC_LEN_C = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // Reject unusable configurations at elaboration time.
  if (VEC_LEN < 1 || VEC_LEN > (1 << ADDR_W) || TIMEOUT < 1) begin : g_param_check
    $error("layer_2_5_sequencer: VEC_LEN must be 1..2^ADDR_W and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ack_cnt;   // datapath step acknowledgements, saturating

`ifdef SEQ_TIMEOUT_EN
  localparam int               WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  logic [WD_W-1:0] wd_cnt;     // cycles spent in DRAIN
`endif

  // Sequencer FSM; every output is a register updated together with the state.
  // rd_addr doubles as the issue counter since it steps 0..VEC_LEN-1 in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_valid  <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      dp_clear      <= 1'b0;
      dp_load       <= 1'b0;
      dp_accumulate <= 1'b0;
      ack_cnt       <= '0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt        <= '0;
      error         <= 1'b0;
`endif
    end else begin
      // Memory returns data one cycle after the read strobe, so the datapath
      // strobes are the read strobe delayed by one register.
      dp_load       <= rd_en;
      dp_accumulate <= rd_en;
      done          <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CLEAR;
            busy     <= 1'b1;
            dp_clear <= 1'b1;
          end
        end

        S_CLEAR: begin
          state    <= S_ISSUE;
          dp_clear <= 1'b0;
          ack_cnt  <= '0;
          rd_en    <= 1'b1;
          rd_addr  <= '0;
        end

        S_ISSUE: begin
          if (dp_accumulate_signal && ack_cnt != VEC_LEN_C) begin
            ack_cnt <= ack_cnt + CNT_ONE;
          end
          if (rd_addr == LAST_ADDR) begin
            state   <= S_DRAIN;
            rd_en   <= 1'b0;
            rd_addr <= '0;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end else begin
            rd_addr <= rd_addr + ADDR_ONE;
          end
        end

        S_DRAIN: begin
          if (ack_cnt == VEC_LEN_C) begin
            state        <= S_RESULT;
            done         <= 1'b1;
            result_valid <= 1'b1;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            // Datapath stalled: give up, flag it, and present what we have.
            state        <= S_RESULT;
            done         <= 1'b1;
            result_valid <= 1'b1;
            error        <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
`endif
          if (dp_accumulate_signal && ack_cnt != VEC_LEN_C) begin
            ack_cnt <= ack_cnt + CNT_ONE;
          end
        end

        S_RESULT: begin
          // start is deliberately not looked at here; a new run can only be
          // accepted from IDLE on a later cycle.
          if (result_ack) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_2_5_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_2_5_sequencer
// Purpose  : Self-checking bench for layer_2_5_sequencer. Two instances
//            (VEC_LEN=4 and VEC_LEN=1) share control inputs and are compared
//            every cycle against a cycle-timeline reference model.
// Options  : define SEQ_TIMEOUT_EN to also exercise the drain watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_2_5_sequencer;

  localparam int TMO = 8;
`ifdef SEQ_TIMEOUT_EN
  localparam int VW = 16;
`else
  localparam int VW = 15;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, result_ack = 1'b0, p4 = 1'b0, p1 = 1'b0;

  logic       busy4, done4, rv4, rd4, clr4, ld4, acc4;
  logic       busy1, done1, rv1, rd1, clr1, ld1, acc1;
  logic [7:0] addr4, addr1;
  logic [VW-1:0] act4, act1;
  logic [VW-1:0] exp_v [2];

  int total = 0, bad = 0, cyc = 0;

  // Clock generation.
  always #5 clk = ~clk;

`ifdef SEQ_TIMEOUT_EN
  logic err4, err1;
  assign act4 = {err4, busy4, done4, rv4, rd4, clr4, ld4, acc4, addr4};
  assign act1 = {err1, busy1, done1, rv1, rd1, clr1, ld1, acc1, addr1};
`else
  assign act4 = {busy4, done4, rv4, rd4, clr4, ld4, acc4, addr4};
  assign act1 = {busy1, done1, rv1, rd1, clr1, ld1, acc1, addr1};
`endif

  layer_2_5_sequencer #(.VEC_LEN(4), .ADDR_W(8), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .reset(reset), .start(start), .result_ack(result_ack),
    .dp_accumulate_signal(p4), .busy(busy4), .done(done4), .result_valid(rv4),
    .rd_en(rd4), .rd_addr(addr4), .dp_clear(clr4), .dp_load(ld4),
`ifdef SEQ_TIMEOUT_EN
    .error(err4),
`endif
    .dp_accumulate(acc4)
  );

  layer_2_5_sequencer #(.VEC_LEN(1), .ADDR_W(8), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset(reset), .start(start), .result_ack(result_ack),
    .dp_accumulate_signal(p1), .busy(busy1), .done(done1), .result_valid(rv1),
    .rd_en(rd1), .rd_addr(addr1), .dp_clear(clr1), .dp_load(ld1),
`ifdef SEQ_TIMEOUT_EN
    .error(err1),
`endif
    .dp_accumulate(acc1)
  );

  // Reference model: a run is a timeline indexed by k = cycles since start
  // was accepted (k=1 clear, k=2..N+1 reads, drain from k=N+2 onward).
  bit m_act [2], m_res [2], m_err [2], m_rd [2], m_done [2];
  int m_k [2], m_acks [2];

  task automatic model_step(input int i, input int n, input bit pulse);
    bit load;
    bit clr;
    logic [7:0] a;
    logic [14:0] v;
    load = m_rd[i];
    m_done[i] = 1'b0;
    if (reset) begin
      m_act[i] = 0; m_res[i] = 0; m_err[i] = 0; m_k[i] = 0; m_acks[i] = 0; load = 0;
    end else if (!m_act[i]) begin
      if (start) begin m_act[i] = 1; m_k[i] = 1; m_acks[i] = 0; end
    end else if (m_res[i]) begin
      if (result_ack) begin m_act[i] = 0; m_res[i] = 0; m_k[i] = 0; end
    end else begin
      if (m_k[i] >= n + 2 && m_acks[i] == n) begin
        m_res[i] = 1; m_done[i] = 1;
      end
`ifdef SEQ_TIMEOUT_EN
      else if (m_k[i] == n + 1 + TMO) begin
        m_res[i] = 1; m_done[i] = 1; m_err[i] = 1;
      end
`endif
      else if (pulse && m_k[i] >= 2 && m_acks[i] < n) begin
        m_acks[i]++;
      end
      m_k[i]++;
    end
    m_rd[i] = m_act[i] && !m_res[i] && m_k[i] >= 2 && m_k[i] <= n + 1;
    clr     = m_act[i] && !m_res[i] && m_k[i] == 1;
    a       = m_rd[i] ? 8'(m_k[i] - 2) : 8'd0;
    v       = {m_act[i], m_done[i], m_res[i], m_rd[i], clr, load, load, a};
`ifdef SEQ_TIMEOUT_EN
    exp_v[i] = {m_err[i], v};
`else
    exp_v[i] = v;
`endif
  endtask

  // Advance both models on every rising edge with the inputs held since the
  // previous falling edge.
  always @(posedge clk) begin
    cyc++;
    model_step(0, 4, p4);
    model_step(1, 1, p1);
  end

  task automatic test_reset();
    reset = 1'b1; start = 0; result_ack = 0; p4 = 0; p1 = 0;
    repeat (3) @(negedge clk);
    total++; if (act4 !== '0) begin bad++; $display("FAIL reset_dut4 got=%h want=0", act4); end
    total++; if (act1 !== '0) begin bad++; $display("FAIL reset_dut1 got=%h want=0", act1); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int n_clr4 = 0, n_rd4 = 0, n_ld4 = 0, n_dn4 = 0, n_rd1 = 0, n_ld1 = 0, n_dn1 = 0;
    int t_clr = -1, t_rd = -1, t_ld = -1;
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++; if (act4 !== exp_v[0]) begin bad++; $display("FAIL basic_dut4 cyc=%0d got=%h want=%h", cyc, act4, exp_v[0]); end
      total++; if (act1 !== exp_v[1]) begin bad++; $display("FAIL basic_dut1 cyc=%0d got=%h want=%h", cyc, act1, exp_v[1]); end
      if (clr4 === 1'b1) begin n_clr4++; if (t_clr < 0) t_clr = c + 1; end
      if (rd4 === 1'b1) begin
        n_rd4++;
        if (t_rd < 0) t_rd = c + 1;
        total++; if (addr4 !== 8'(c - 1)) begin bad++; $display("FAIL basic_addr got=%0d want=%0d", addr4, c - 1); end
      end
      if (ld4 === 1'b1) begin n_ld4++; if (t_ld < 0) t_ld = c + 1; end
      if (done4 === 1'b1) n_dn4++;
      if (rd1 === 1'b1) n_rd1++;
      if (ld1 === 1'b1) n_ld1++;
      if (done1 === 1'b1) n_dn1++;
      start = 1'b0;
      p4 = ($urandom_range(0, 1) == 1);
      p1 = ($urandom_range(0, 1) == 1);
      result_ack = (m_res[0] || m_res[1]) && ($urandom_range(0, 2) == 0);
    end
    result_ack = 0;
    total++; if (t_clr !== 1) begin bad++; $display("FAIL basic_clear_cycle got=%0d want=1", t_clr); end
    total++; if (t_rd !== 2)  begin bad++; $display("FAIL basic_rd_cycle got=%0d want=2", t_rd); end
    total++; if (t_ld !== 3)  begin bad++; $display("FAIL basic_load_cycle got=%0d want=3", t_ld); end
    total++; if (n_clr4 !== 1) begin bad++; $display("FAIL basic_clear_count got=%0d want=1", n_clr4); end
    total++; if (n_rd4 !== 4) begin bad++; $display("FAIL basic_rd_count got=%0d want=4", n_rd4); end
    total++; if (n_ld4 !== 4) begin bad++; $display("FAIL basic_load_count got=%0d want=4", n_ld4); end
    total++; if (n_dn4 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", n_dn4); end
    total++; if (n_rd1 !== 1) begin bad++; $display("FAIL vec1_rd_count got=%0d want=1", n_rd1); end
    total++; if (n_ld1 !== 1) begin bad++; $display("FAIL vec1_load_count got=%0d want=1", n_ld1); end
    total++; if (n_dn1 !== 1) begin bad++; $display("FAIL vec1_done_count got=%0d want=1", n_dn1); end
    total++; if (busy4 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL basic_end_idle got=%b%b want=00", busy4, busy1); end
  endtask

  task automatic test_restart_ignored();
    int n_clr4 = 0, n_dn4 = 0, res_cyc = 0;
    bit ack_given = 0, restarted = 0;
    start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      total++; if (act4 !== exp_v[0]) begin bad++; $display("FAIL restart_dut4 cyc=%0d got=%h want=%h", cyc, act4, exp_v[0]); end
      total++; if (act1 !== exp_v[1]) begin bad++; $display("FAIL restart_dut1 cyc=%0d got=%h want=%h", cyc, act1, exp_v[1]); end
      if (clr4 === 1'b1) n_clr4++;
      if (done4 === 1'b1) n_dn4++;
      if (m_res[0] && !ack_given) begin
        res_cyc++;
        start = 1'b1;
        result_ack = (res_cyc == 3);
        if (res_cyc == 3) ack_given = 1;
      end else if (ack_given && !restarted) begin
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL ack_start_idle got=%b want=0", busy4); end
        start = 1'b1; result_ack = 1'b0; restarted = 1;
      end else if (restarted) begin
        start = 1'b0; result_ack = m_res[0] || m_res[1];
      end else begin
        start = ($urandom_range(0, 1) == 1); result_ack = 1'b0;
      end
      p4 = ($urandom_range(0, 1) == 1);
      p1 = ($urandom_range(0, 1) == 1);
    end
    start = 0; result_ack = 0;
    total++; if (n_clr4 !== 2) begin bad++; $display("FAIL restart_clear_count got=%0d want=2", n_clr4); end
    total++; if (n_dn4 !== 2) begin bad++; $display("FAIL restart_done_count got=%0d want=2", n_dn4); end
  endtask

  task automatic test_reset_midrun();
    int n_rd4 = 0, n_dn4 = 0;
    bit hit = 0;
    start = 1'b1; result_ack = 0; p4 = 0; p1 = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      total++; if (act4 !== exp_v[0]) begin bad++; $display("FAIL midrun_dut4 cyc=%0d got=%h want=%h", cyc, act4, exp_v[0]); end
      start = 1'b0;
      if (m_act[0] && m_k[0] == 3) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL midrun_reach_issue got=0 want=1"); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (act4 !== '0) begin bad++; $display("FAIL midrun_abort_dut4 got=%h want=0", act4); end
    total++; if (act1 !== '0) begin bad++; $display("FAIL midrun_abort_dut1 got=%h want=0", act1); end
    reset = 1'b0; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++; if (act4 !== exp_v[0]) begin bad++; $display("FAIL rerun_dut4 cyc=%0d got=%h want=%h", cyc, act4, exp_v[0]); end
      total++; if (act1 !== exp_v[1]) begin bad++; $display("FAIL rerun_dut1 cyc=%0d got=%h want=%h", cyc, act1, exp_v[1]); end
      if (rd4 === 1'b1) n_rd4++;
      if (done4 === 1'b1) n_dn4++;
      start = 1'b0;
      p4 = ($urandom_range(0, 1) == 1);
      p1 = ($urandom_range(0, 1) == 1);
      result_ack = m_res[0] || m_res[1];
    end
    result_ack = 0;
    total++; if (n_rd4 !== 4 || n_dn4 !== 1) begin bad++; $display("FAIL rerun_counts got=%0d/%0d want=4/1", n_rd4, n_dn4); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++; if (act4 !== exp_v[0]) begin bad++; $display("FAIL random_dut4 cyc=%0d got=%h want=%h", cyc, act4, exp_v[0]); end
      total++; if (act1 !== exp_v[1]) begin bad++; $display("FAIL random_dut1 cyc=%0d got=%h want=%h", cyc, act1, exp_v[1]); end
      start      = ($urandom_range(0, 3) == 0);
      result_ack = ($urandom_range(0, 2) == 0);
      p4         = ($urandom_range(0, 1) == 1);
      p1         = ($urandom_range(0, 1) == 1);
      reset      = ($urandom_range(0, 49) == 0);
    end
    reset = 0; start = 0; result_ack = 0; p4 = 0; p1 = 0;
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t_done = -1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; result_ack = 0; p1 = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      total++; if (act4 !== exp_v[0]) begin bad++; $display("FAIL tmo_dut4 cyc=%0d got=%h want=%h", cyc, act4, exp_v[0]); end
      total++; if (act1 !== exp_v[1]) begin bad++; $display("FAIL tmo_dut1 cyc=%0d got=%h want=%h", cyc, act1, exp_v[1]); end
      if (done4 === 1'b1 && t_done < 0) t_done = c + 1;
      start = 1'b0;
      p4 = m_act[0] && m_k[0] >= 2 && m_k[0] <= 4;
      result_ack = (c >= 20);
    end
    result_ack = 0;
    total++; if (t_done !== 14) begin bad++; $display("FAIL tmo_done_cycle got=%0d want=14", t_done); end
    total++; if (err4 !== 1'b1 || busy4 !== 1'b0) begin bad++; $display("FAIL tmo_sticky got=%b/%b want=1/0", err4, busy4); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (err4 !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b want=0", err4); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_restart_ignored();
    test_reset_midrun();
    test_random();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
